// File: rtl/bt_cmd_scheduler.sv
// Bluetooth command scheduler: FIFO-buffered UART command bytes decoded into seek/volume
// requests for the player core. Optional ECHO state enabled by defining BT_SCHED_ECHO_EN.
module bt_cmd_scheduler #(
   parameter int TRACKS     = 7,
   parameter int FIFO_DEPTH = 4,
   parameter int VOL_MAX    = 15,
   parameter int VOL_INIT   = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_VALID,
   input  logic [7:0] RX_DATA,
   output logic       CMD_VALID,
   output logic       CMD_OP,
   output logic [2:0] CMD_TRACK,
   output logic [3:0] CMD_VOL,
   input  logic       CMD_ACK,
   output logic [2:0] TRACK,
   output logic [3:0] VOLUME,
`ifdef BT_SCHED_ECHO_EN
   output logic       TX_VALID,
   output logic [7:0] TX_DATA,
   input  logic       TX_READY,
`endif
   output logic       FIFO_FULL,
   output logic [7:0] DROP_CNT
);

   localparam int                AW        = $clog2(FIFO_DEPTH);
   localparam logic [2:0]        TRK_LAST  = 3'(TRACKS - 1);
   localparam logic [3:0]        TRK_NUM   = 4'(TRACKS);
   localparam logic [3:0]        VOL_MAX_V = 4'(VOL_MAX);
   localparam logic signed [5:0] VOL_MAX_S = 6'(VOL_MAX);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      ISSUE
`ifdef BT_SCHED_ECHO_EN
      , ECHO
`endif
   } state_t;

   state_t state, state_nxt;

   logic [3:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   fifo_cnt;
   logic          fifo_empty, byte_ok, push, pop, drop;
   logic [3:0]    cmd_p0;
   logic          is_vol, discard;
   logic [2:0]    seek_tgt;
   logic [3:0]    vol_tgt, abs_trk;

   function automatic logic [3:0] vol_sat(input logic signed [5:0] v);
      if (v < 6'sd0)
         return 4'd0;
      if (v > VOL_MAX_S)
         return VOL_MAX_V;
      return v[3:0];
   endfunction

   assign byte_ok    = (RX_DATA >= 8'h01) && (RX_DATA <= 8'h0B);
   assign fifo_empty = (fifo_cnt == '0);
   assign FIFO_FULL  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
   assign pop        = (state == IDLE) && !fifo_empty;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push       = RX_VALID && byte_ok && (!FIFO_FULL || pop);
   assign drop       = RX_VALID && byte_ok && FIFO_FULL && !pop;
   assign CMD_VALID  = (state == ISSUE);

   // Stage p0: FIFO storage and popped command byte (data only, no reset)
   always_ff @(posedge CLK) begin
      if (push)
         fifo_mem[wr_ptr] <= RX_DATA[3:0];
      if (pop)
         cmd_p0 <= fifo_mem[rd_ptr];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         DROP_CNT <= 8'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            fifo_cnt <= fifo_cnt + (AW+1)'(1);
         else if (pop && !push)
            fifo_cnt <= fifo_cnt - (AW+1)'(1);
         if (drop && (DROP_CNT != 8'hFF))
            DROP_CNT <= DROP_CNT + 8'd1;
      end
   end

   // Stage p1: decode against the already-updated TRACK/VOLUME
   always_comb begin
      is_vol   = 1'b0;
      discard  = 1'b0;
      seek_tgt = TRACK;
      vol_tgt  = VOLUME;
      abs_trk  = cmd_p0 - 4'd5;
      case (cmd_p0)
         4'h1: seek_tgt = (TRACK == 3'd0) ? TRK_LAST : TRACK - 3'd1;
         4'h2: seek_tgt = (TRACK == TRK_LAST) ? 3'd0 : TRACK + 3'd1;
         4'h3: begin
            is_vol  = 1'b1;
            vol_tgt = vol_sat($signed({2'b00, VOLUME}) + 6'sd1);
            discard = (vol_tgt == VOLUME);
         end
         4'h4: begin
            is_vol  = 1'b1;
            vol_tgt = vol_sat($signed({2'b00, VOLUME}) - 6'sd1);
            discard = (vol_tgt == VOLUME);
         end
         default: begin
            seek_tgt = abs_trk[2:0];
            discard  = (abs_trk >= TRK_NUM) || (abs_trk[2:0] == TRACK);
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!fifo_empty) state_nxt = EXEC;
`ifdef BT_SCHED_ECHO_EN
         EXEC:  state_nxt = discard ? ECHO : ISSUE;
         ISSUE: if (CMD_ACK) state_nxt = ECHO;
         ECHO:  if (TX_READY) state_nxt = IDLE;
`else
         EXEC:  state_nxt = discard ? IDLE : ISSUE;
         ISSUE: if (CMD_ACK) state_nxt = IDLE;
`endif
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p2: request registers and player state, committed on acknowledge
   always_ff @(posedge CLK) begin
      if (RST) begin
         CMD_OP    <= 1'b0;
         CMD_TRACK <= 3'd0;
         CMD_VOL   <= 4'(VOL_INIT);
         TRACK     <= 3'd0;
         VOLUME    <= 4'(VOL_INIT);
      end else begin
         if ((state == EXEC) && !discard) begin
            CMD_OP <= is_vol;
            if (is_vol)
               CMD_VOL <= vol_tgt;
            else
               CMD_TRACK <= seek_tgt;
         end
         if ((state == ISSUE) && CMD_ACK) begin
            if (CMD_OP)
               VOLUME <= CMD_VOL;
            else
               TRACK <= CMD_TRACK;
         end
      end
   end

`ifdef BT_SCHED_ECHO_EN
   logic [7:0] tx_data_p2;

   always_ff @(posedge CLK) begin
      if ((state == EXEC) && discard)
         tx_data_p2 <= 8'hFF;
      else if ((state == ISSUE) && CMD_ACK)
         tx_data_p2 <= CMD_OP ? {2'b11, 2'b00, CMD_VOL} : {2'b10, 3'b000, CMD_TRACK};
   end

   assign TX_VALID = (state == ECHO);
   assign TX_DATA  = tx_data_p2;
`endif

endmodule

// File: tb/tb_bt_cmd_scheduler.sv
// Self-checking bench for bt_cmd_scheduler: directed vectors plus a queue-based
// behavioural model of the request sequence checked on every clock.
module tb_bt_cmd_scheduler;

   localparam int TRACKS  = 7;
   localparam int VOL_MAX = 15;
   localparam int VOL_INIT = 8;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RX_VALID = 1'b0;
   logic [7:0] RX_DATA = 8'h00;
   logic       CMD_VALID, CMD_OP;
   logic [2:0] CMD_TRACK, TRACK;
   logic [3:0] CMD_VOL, VOLUME;
   logic       CMD_ACK = 1'b0;
   logic       FIFO_FULL;
   logic [7:0] DROP_CNT;
`ifdef BT_SCHED_ECHO_EN
   logic       TX_VALID;
   logic [7:0] TX_DATA;
   logic       TX_READY = 1'b1;
`endif

   bt_cmd_scheduler #(.TRACKS(TRACKS), .FIFO_DEPTH(4), .VOL_MAX(VOL_MAX), .VOL_INIT(VOL_INIT)) dut (
      .CLK(CLK), .RST(RST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
      .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP), .CMD_TRACK(CMD_TRACK), .CMD_VOL(CMD_VOL),
      .CMD_ACK(CMD_ACK), .TRACK(TRACK), .VOLUME(VOLUME),
`ifdef BT_SCHED_ECHO_EN
      .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
`endif
      .FIFO_FULL(FIFO_FULL), .DROP_CNT(DROP_CNT)
   );

   always #5 CLK = ~CLK;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Behavioural model: accepted bytes in arrival order, player state, drop count.
   int  q[$];
   int  m_track, m_vol, m_drop, n_acks;
   bit  model_on = 0;
   bit  have_req = 0;
   bit  req_op;
   int  req_tgt;
   bit  exp_fall = 0;
   bit  exp_drop = 0;

   function automatic bit resolve(output bit op, output int tgt);
      int b;
      op = 0;
      tgt = 0;
      while (q.size() > 0) begin
         b = q.pop_front();
         case (b)
            1: begin op = 0; tgt = (m_track + TRACKS - 1) % TRACKS; return 1; end
            2: begin op = 0; tgt = (m_track + 1) % TRACKS; return 1; end
            3: if (m_vol < VOL_MAX) begin op = 1; tgt = m_vol + 1; return 1; end
            4: if (m_vol > 0) begin op = 1; tgt = m_vol - 1; return 1; end
            default: if ((b - 5) < TRACKS && (b - 5) != m_track) begin
               op = 0; tgt = b - 5; return 1;
            end
         endcase
      end
      return 0;
   endfunction

   always @(negedge CLK) begin
      if (model_on) begin
         chk("track", TRACK, m_track);
         chk("volume", VOLUME, m_vol);
         chk("drop_cnt", DROP_CNT, m_drop);
         if (exp_fall)
            chk("valid_fall_after_ack", CMD_VALID, 0);
         if (CMD_VALID) begin
            if (!have_req) begin
               have_req = resolve(req_op, req_tgt);
               chk("request_expected", have_req, 1);
            end
            if (have_req) begin
               chk("cmd_op", CMD_OP, req_op);
               if (req_op)
                  chk("cmd_vol", CMD_VOL, req_tgt);
               else
                  chk("cmd_track", CMD_TRACK, req_tgt);
            end
         end else if (have_req) begin
            chk("request_held", CMD_VALID, 1);
            have_req = 0;
         end
      end
      exp_fall = 0;
      if (RST) begin
         q.delete();
         m_track = 0;
         m_vol = VOL_INIT;
         m_drop = 0;
         have_req = 0;
         model_on = 1;
      end else if (model_on) begin
         if (CMD_VALID && CMD_ACK && have_req) begin
            if (req_op) m_vol = req_tgt;
            else        m_track = req_tgt;
            have_req = 0;
            exp_fall = 1;
            n_acks++;
         end
         if (RX_VALID && RX_DATA >= 8'h01 && RX_DATA <= 8'h0B) begin
            if (exp_drop) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
            else          q.push_back(int'(RX_DATA));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit dropped);
      RX_VALID = 1'b1;
      RX_DATA  = b;
      exp_drop = dropped;
      tick();
      RX_VALID = 1'b0;
      exp_drop = 0;
   endtask

   task automatic wait_valid(input string name, input int max);
      int i = 0;
      while (!CMD_VALID && i < max) begin
         tick();
         i++;
      end
      chk(name, CMD_VALID, 1);
   endtask

   task automatic expect_no_req(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(name, CMD_VALID, 0);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic chk_drained();
      bit op;
      int tg;
      chk("no_pending_request", resolve(op, tg), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      // Reset state
      do_reset();
      chk("rst_cmd_valid", CMD_VALID, 0);
      chk("rst_cmd_op", CMD_OP, 0);
      chk("rst_cmd_track", CMD_TRACK, 0);
      chk("rst_cmd_vol", CMD_VOL, 8);
      chk("rst_track", TRACK, 0);
      chk("rst_volume", VOLUME, 8);
      chk("rst_fifo_full", FIFO_FULL, 0);
      chk("rst_drop_cnt", DROP_CNT, 0);

      // Latency: byte in cycle t, request in cycle t+3
      CMD_ACK = 1'b1;
      send(8'h02, 0);
      chk("lat_t1", CMD_VALID, 0);
      tick();
      chk("lat_t2", CMD_VALID, 0);
      tick();
      chk("lat_t3", CMD_VALID, 1);
      chk("lat_op", CMD_OP, 0);
      chk("lat_track", CMD_TRACK, 1);
      tick();
      chk("lat_track_after", TRACK, 1);
      chk("lat_valid_after", CMD_VALID, 0);

      // Wrap in both directions
      do_reset();
      send(8'h01, 0);
      wait_valid("wrap_dn_valid", 6);
      chk("wrap_dn_track", CMD_TRACK, 6);
      tick();
      chk("wrap_dn_state", TRACK, 6);
      send(8'h02, 0);
      wait_valid("wrap_up_valid", 6);
      chk("wrap_up_track", CMD_TRACK, 0);
      tick();
      chk("wrap_up_state", TRACK, 0);

      // Volume saturation
      for (int i = 0; i < 7; i++) begin
         send(8'h03, 0);
         wait_valid("vol_up_valid", 6);
         chk("vol_up_target", CMD_VOL, 9 + i);
         tick();
      end
      chk("vol_at_max", VOLUME, 15);
      send(8'h03, 0);
      expect_no_req("vol_sat_discard", 6);
      chk("vol_stays_max", VOLUME, 15);
      send(8'h04, 0);
      wait_valid("vol_dn_valid", 6);
      chk("vol_dn_op", CMD_OP, 1);
      chk("vol_dn_target", CMD_VOL, 14);
      tick();
      chk("vol_dn_state", VOLUME, 14);

      // Absolute seeks and ignored bytes
      send(8'h08, 0);
      wait_valid("abs3_valid", 6);
      chk("abs3_track", CMD_TRACK, 3);
      tick();
      chk("abs3_state", TRACK, 3);
      send(8'h08, 0);
      expect_no_req("abs_same_discard", 6);
      send(8'h0B, 0);
      wait_valid("abs6_valid", 6);
      chk("abs6_track", CMD_TRACK, 6);
      tick();
      send(8'h0C, 0);
      send(8'h00, 0);
      send(8'hFF, 0);
      expect_no_req("ignored_bytes", 6);
      chk("ignored_no_drop", DROP_CNT, 0);
      chk_drained();

      // Overflow with acknowledge held off, then drop-count saturation
      do_reset();
      CMD_ACK = 1'b0;
      for (int i = 0; i < 5; i++)
         send(8'h02, 0);
      send(8'h02, 1);
      chk("ovf_full", FIFO_FULL, 1);
      chk("ovf_drop1", DROP_CNT, 1);
      chk("ovf_valid", CMD_VALID, 1);
      chk("ovf_first_track", CMD_TRACK, 1);
      for (int i = 0; i < 260; i++)
         send(8'h02, 1);
      chk("drop_saturated", DROP_CNT, 255);
      a0 = n_acks;
      CMD_ACK = 1'b1;
      repeat (30) tick();
      chk("ovf_seek_count", n_acks - a0, 5);
      chk("ovf_final_track", TRACK, 5);
      chk("ovf_full_clear", FIFO_FULL, 0);
      chk_drained();

      // Reset during ISSUE with acknowledge in the reset cycle
      send(8'h04, 0);
      wait_valid("pre_rst_vol_valid", 6);
      chk("pre_rst_vol", CMD_VOL, 7);
      tick();
      chk("pre_rst_volume", VOLUME, 7);
      CMD_ACK = 1'b0;
      send(8'h01, 0);
      wait_valid("pre_rst_seek_valid", 6);
      chk("pre_rst_seek", CMD_TRACK, 4);
      send(8'h02, 0);
      RST = 1'b1;
      CMD_ACK = 1'b1;
      tick();
      RST = 1'b0;
      CMD_ACK = 1'b0;
      chk("midrst_valid", CMD_VALID, 0);
      chk("midrst_track", TRACK, 0);
      chk("midrst_volume", VOLUME, 8);
      chk("midrst_full", FIFO_FULL, 0);
      chk("midrst_drop", DROP_CNT, 0);
      CMD_ACK = 1'b1;
      expect_no_req("midrst_fifo_empty", 8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
